coin_pulse_sched: RTL and testbench

- Per-channel scheduler between the keyboard/joystick decode and the game core's coin/service inputs.
- Turns each rising edge on a level request (coin key held for any duration) into exactly one fixed-length pulse, timed in frame ticks.
- Enforces a minimum low gap between pulses, so the game CPU samples every press.
- Queues rapid presses per channel in a saturating pending counter and drains them in order.

---
 rtl/coin_pulse_sched_if.sv | 23 ++
 rtl/coin_pulse_sched.sv | 142 ++++++++++++++
 tb/tb_coin_pulse_sched.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/coin_pulse_sched_if.sv
// Handshake bundle between the key decode and the coin pulse scheduler.
// Ports: tick, freeze, req in; coin_out, pulse_start, pending_nz, busy out.
interface coin_pulse_sched_if #(
    parameter int NUM_CH = 4
);
    logic              tick;
    logic              freeze;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] coin_out;
    logic [NUM_CH-1:0] pulse_start;
    logic [NUM_CH-1:0] pending_nz;
    logic              busy;

    modport master (
        output tick, freeze, req,
        input  coin_out, pulse_start, pending_nz, busy
    );

    modport slave (
        input  tick, freeze, req,
        output coin_out, pulse_start, pending_nz, busy
    );
endinterface

// File: rtl/coin_pulse_sched.sv
// Per-channel coin/service pulse scheduler timed in frame ticks.
// Ports: clk, reset (sync, active-high), bus (slave: tick, freeze, req,
// coin_out, pulse_start, pending_nz, busy).
module coin_pulse_sched #(
    parameter int NUM_CH      = 4,
    parameter int PULSE_TICKS = 3,
    parameter int GAP_TICKS   = 3,
    parameter int PEND_W      = 3,
    parameter bit ACTIVE_LOW  = 1'b0
) (
    input logic               clk,
    input logic               reset,
    coin_pulse_sched_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP
    } state_t;

    localparam logic [3:0]        PULSE_CNT = 4'(PULSE_TICKS);
    localparam logic [3:0]        GAP_CNT   = 4'(GAP_TICKS);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;

    state_t            state   [NUM_CH];
    state_t            state_n [NUM_CH];
    logic [3:0]        cnt     [NUM_CH];
    logic [3:0]        cnt_n   [NUM_CH];
    logic [PEND_W-1:0] pend    [NUM_CH];
    logic [PEND_W-1:0] pend_n  [NUM_CH];

    logic [NUM_CH-1:0] req_q;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] start;
    logic [NUM_CH-1:0] start_q;
    logic [NUM_CH-1:0] deq;
    logic [NUM_CH-1:0] inc;
    logic [NUM_CH-1:0] active;
    logic [NUM_CH-1:0] pnz;
    logic              busy_v;
    logic              step;

    assign rise = bus.req & ~req_q;
    assign step = bus.tick & ~bus.freeze;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_n[i] = state[i];
            cnt_n[i]   = cnt[i];
            pend_n[i]  = pend[i];
            start[i]   = 1'b0;
            deq[i]     = 1'b0;
            inc[i]     = 1'b0;

            unique case (state[i])
                IDLE: begin
                    if (!bus.freeze && (pend[i] != '0 || rise[i])) begin
                        start[i]   = 1'b1;
                        state_n[i] = PULSE;
                        cnt_n[i]   = PULSE_CNT;
                    end
                end
                PULSE: begin
                    if (step) begin
                        if (cnt[i] == 4'd1) begin
                            if (GAP_TICKS > 0) begin
                                state_n[i] = GAP;
                                cnt_n[i]   = GAP_CNT;
                            end else begin
                                state_n[i] = IDLE;
                                cnt_n[i]   = '0;
                            end
                        end else begin
                            cnt_n[i] = cnt[i] - 4'd1;
                        end
                    end
                end
                GAP: begin
                    if (step) begin
                        if (cnt[i] == 4'd1) begin
                            state_n[i] = IDLE;
                            cnt_n[i]   = '0;
                        end else begin
                            cnt_n[i] = cnt[i] - 4'd1;
                        end
                    end
                end
                default: begin
                    state_n[i] = IDLE;
                    cnt_n[i]   = '0;
                end
            endcase

            // A start with an empty queue swallows the edge directly;
            // any other edge is queued.
            deq[i] = start[i] && (pend[i] != '0);
            inc[i] = rise[i] && !(start[i] && (pend[i] == '0));

            if (inc[i] && !deq[i]) begin
                if (pend[i] != PEND_MAX) begin
                    pend_n[i] = pend[i] + 1'b1;
                end
            end else if (deq[i] && !inc[i]) begin
                pend_n[i] = pend[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q   <= '0;
            start_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
                pend[i]  <= '0;
            end
        end else begin
            req_q   <= bus.req;
            start_q <= start;
            for (int i = 0; i < NUM_CH; i++) begin
                state[i] <= state_n[i];
                cnt[i]   <= cnt_n[i];
                pend[i]  <= pend_n[i];
            end
        end
    end

    always_comb begin
        busy_v = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            active[i] = (state[i] == PULSE);
            pnz[i]    = (pend[i] != '0);
            busy_v    = busy_v | (state[i] != IDLE) | pnz[i];
        end
    end

    assign bus.coin_out    = ACTIVE_LOW ? ~active : active;
    assign bus.pulse_start = start_q;
    assign bus.pending_nz  = pnz;
    assign bus.busy        = busy_v;
endmodule

// File: tb/tb_coin_pulse_sched.sv
// Self-checking bench for coin_pulse_sched.
// Ports: none; drives two DUT instances through their interfaces.
module tb_coin_pulse_sched;
    localparam int N  = 4;
    localparam int PT = 3;
    localparam int GT = 3;

    logic clk = 1'b0;
    logic reset;
    logic reset_b;

    always #5 clk = ~clk;

    coin_pulse_sched_if #(.NUM_CH(N)) bus_a ();
    coin_pulse_sched_if #(.NUM_CH(N)) bus_b ();

    coin_pulse_sched #(
        .NUM_CH(N), .PULSE_TICKS(PT), .GAP_TICKS(GT),
        .PEND_W(3), .ACTIVE_LOW(1'b0)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );

    coin_pulse_sched #(
        .NUM_CH(N), .PULSE_TICKS(PT), .GAP_TICKS(0),
        .PEND_W(3), .ACTIVE_LOW(1'b1)
    ) dut_b (
        .clk(clk), .reset(reset_b), .bus(bus_b)
    );

    typedef struct {
        logic       rst;
        logic       tk;
        logic       frz;
        logic [3:0] req;
        logic [3:0] push;
        logic [3:0] coin;
        logic [3:0] ps;
        logic [3:0] pnz;
        logic       busy;
    } vec_t;

    vec_t tbl [29];

    int n_vec = 0;
    int n_bad = 0;
    int tph = 0;
    int sb [N][$];
    int exp_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic step();
        bus_a.tick = (tph == 9);
        bus_b.tick = (tph == 9);
        tph = (tph + 1) % 10;
        cyc();
    endtask

    // Monitor on dut_a: tick-accurate pulse width against the
    // scoreboard, minimum gap, and pulse_start aligned with rises.
    logic [N-1:0] prev_coin = '0;
    int           hi_t [N];
    int           lo_t [N];
    bit           had  [N];

    always @(negedge clk) begin
        if (reset) begin
            prev_coin = '0;
            for (int i = 0; i < N; i++) begin
                hi_t[i] = 0;
                lo_t[i] = 0;
                had[i]  = 1'b0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (bus_a.coin_out[i]) begin
                    if (!prev_coin[i]) begin
                        if (had[i])
                            chk("gap_ticks_min", lo_t[i] >= GT, 1);
                        hi_t[i] = 0;
                    end
                    if (bus_a.tick && !bus_a.freeze) hi_t[i]++;
                end else begin
                    if (prev_coin[i]) begin
                        if (sb[i].size() == 0) begin
                            n_vec++;
                            n_bad++;
                            $display("FAIL unexpected_pulse ch%0d at %0t",
                                     i, $time);
                        end else begin
                            exp_t = sb[i].pop_front();
                            chk("pulse_ticks", hi_t[i], exp_t);
                        end
                        lo_t[i] = 0;
                        had[i]  = 1'b1;
                    end
                    if (bus_a.tick && !bus_a.freeze) lo_t[i]++;
                end
                if (bus_a.pulse_start[i] ||
                    (bus_a.coin_out[i] && !prev_coin[i]))
                    chk("ps_vs_rise", bus_a.pulse_start[i],
                        bus_a.coin_out[i] & ~prev_coin[i]);
                prev_coin[i] = bus_a.coin_out[i];
            end
        end
    end

    task automatic wait_idle_a(input int ch, input int starts0,
                               input int total, input int budget);
        int   starts;
        int   n;
        logic last_tk;
        starts  = starts0;
        n       = 0;
        last_tk = 1'b0;
        while (n < budget) begin
            step();
            n++;
            last_tk = bus_a.tick;
            if (bus_a.pulse_start[ch]) begin
                starts++;
                chk("pnz_at_start", bus_a.pending_nz[ch], starts < total);
            end
            if (!bus_a.busy) break;
        end
        chk("idle_in_budget", bus_a.busy, 0);
        chk("pulse_count", starts, total);
        chk("idle_after_tick", last_tk, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int   nt;
        bit   ok;
        logic last_tk;

        //          rst   tk    frz   req   push  coin  ps    pnz   busy
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 1'b1};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h1, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 1'b1};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1};
        tbl[16] = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 1'b1, 4'h8, 4'h8, 4'h0, 4'h0, 4'h8, 1'b1};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 4'h8, 4'h0, 4'h8, 4'h8, 4'h0, 1'b1};
        tbl[20] = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 1'b1};
        tbl[21] = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 1'b1};
        tbl[22] = '{1'b0, 1'b1, 1'b0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 1'b1};
        tbl[23] = '{1'b0, 1'b1, 1'b0, 4'h4, 4'h0, 4'h4, 4'h0, 4'h0, 1'b1};
        tbl[24] = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 1'b1};
        tbl[25] = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1};
        tbl[26] = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1};
        tbl[27] = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1};
        tbl[28] = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};

        reset        = 1'b1;
        reset_b      = 1'b1;
        bus_a.tick   = 1'b0;
        bus_a.freeze = 1'b0;
        bus_a.req    = '0;
        bus_b.tick   = 1'b0;
        bus_b.freeze = 1'b0;
        bus_b.req    = '0;
        cyc();
        cyc();

        chk("b_reset_coin", bus_b.coin_out, 4'hF);
        chk("b_reset_busy", bus_b.busy, 0);

        for (int k = 0; k < 29; k++) begin
            reset        = tbl[k].rst;
            bus_a.tick   = tbl[k].tk;
            bus_b.tick   = tbl[k].tk;
            bus_a.freeze = tbl[k].frz;
            bus_a.req    = tbl[k].req;
            for (int i = 0; i < N; i++)
                if (tbl[k].push[i]) sb[i].push_back(PT);
            cyc();
            chk($sformatf("tbl%0d_coin", k), bus_a.coin_out, tbl[k].coin);
            chk($sformatf("tbl%0d_ps", k), bus_a.pulse_start, tbl[k].ps);
            chk($sformatf("tbl%0d_pnz", k), bus_a.pending_nz, tbl[k].pnz);
            chk($sformatf("tbl%0d_busy", k), bus_a.busy, tbl[k].busy);
        end
        bus_a.freeze = 1'b0;
        bus_a.req    = '0;
        tph          = 0;

        // Single press on ch0.
        bus_a.req = 4'h1;
        sb[0].push_back(PT);
        step();
        chk("single_coin", bus_a.coin_out[0], 1);
        chk("single_ps", bus_a.pulse_start[0], 1);
        bus_a.req = 4'h0;
        nt        = 0;
        last_tk   = 1'b0;
        for (int n = 0; n < 100; n++) begin
            step();
            last_tk = bus_a.tick;
            if (bus_a.tick) nt++;
            if (!bus_a.coin_out[0]) break;
        end
        chk("single_fall", bus_a.coin_out[0], 0);
        chk("single_ticks", nt, PT);
        chk("single_fall_on_tick", last_tk, 1);
        wait_idle_a(0, 1, 1, 100);

        // Burst of 4 edges on ch1.
        bus_a.req = 4'h2;
        sb[1].push_back(PT);
        step();
        chk("burst_first_ps", bus_a.pulse_start[1], 1);
        for (int r = 0; r < 3; r++) begin
            bus_a.req = 4'h0;
            step();
            bus_a.req = 4'h2;
            sb[1].push_back(PT);
            step();
        end
        bus_a.req = 4'h0;
        chk("burst_pnz", bus_a.pending_nz[1], 1);
        wait_idle_a(1, 1, 4, 600);

        // Saturation on ch3: 1 in flight plus 7 queued.
        bus_a.req = 4'h8;
        sb[3].push_back(PT);
        step();
        for (int r = 0; r < 10; r++) begin
            bus_a.req = 4'h0;
            step();
            bus_a.req = 4'h8;
            step();
        end
        bus_a.req = 4'h0;
        for (int r = 0; r < 7; r++) sb[3].push_back(PT);
        wait_idle_a(3, 1, 8, 1000);

        // Freeze mid-pulse on ch0 with an edge queued during freeze.
        bus_a.req = 4'h1;
        sb[0].push_back(PT);
        step();
        bus_a.req = 4'h0;
        for (int n = 0; n < 15; n++) step();
        chk("frz_pre_coin", bus_a.coin_out[0], 1);
        bus_a.freeze = 1'b1;
        ok = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if (n == 50) begin
                bus_a.req = 4'h1;
                sb[0].push_back(PT);
            end
            step();
            if (n == 50) begin
                chk("frz_edge_pnz", bus_a.pending_nz[0], 1);
                bus_a.req = 4'h0;
            end
            if (!bus_a.coin_out[0]) ok = 1'b0;
        end
        chk("frz_coin_held", ok, 1);
        bus_a.freeze = 1'b0;
        wait_idle_a(0, 1, 2, 400);

        // Reset mid-pulse with 2 queued on active-low dut_b.
        reset_b   = 1'b0;
        bus_b.req = 4'h1;
        step();
        chk("b_start_coin", bus_b.coin_out, 4'hE);
        for (int r = 0; r < 2; r++) begin
            bus_b.req = 4'h0;
            step();
            bus_b.req = 4'h1;
            step();
        end
        bus_b.req = 4'h0;
        chk("b_pnz_before", bus_b.pending_nz, 4'h1);
        chk("b_still_active", bus_b.coin_out[0], 0);
        reset_b = 1'b1;
        step();
        chk("b_rst_coin", bus_b.coin_out, 4'hF);
        chk("b_rst_pnz", bus_b.pending_nz, 4'h0);
        chk("b_rst_busy", bus_b.busy, 0);
        reset_b = 1'b0;
        ok      = 1'b1;
        for (int n = 0; n < 60; n++) begin
            step();
            if (bus_b.coin_out != 4'hF || bus_b.pulse_start != 4'h0)
                ok = 1'b0;
        end
        chk("b_no_pulse_after_rst", ok, 1);

        // GAP_TICKS=0: ch0 and ch3 together, back-to-back.
        bus_b.req = 4'h9;
        step();
        chk("g0_ps", bus_b.pulse_start, 4'h9);
        chk("g0_coin", bus_b.coin_out, 4'h6);
        bus_b.req = 4'h0;
        step();
        step();
        bus_b.req = 4'h9;
        step();
        chk("g0_pnz", bus_b.pending_nz, 4'h9);
        for (int n = 0; n < 100; n++) begin
            step();
            if (bus_b.coin_out[0]) break;
        end
        chk("g0_idle_pass", bus_b.coin_out, 4'hF);
        step();
        chk("g0_restart_coin", bus_b.coin_out, 4'h6);
        chk("g0_restart_ps", bus_b.pulse_start, 4'h9);
        for (int n = 0; n < 100; n++) begin
            step();
            if (!bus_b.busy) break;
        end
        chk("g0_idle", bus_b.busy, 0);
        chk("g0_final_coin", bus_b.coin_out, 4'hF);
        bus_b.req = 4'h0;

        step();
        step();
        for (int i = 0; i < N; i++)
            chk($sformatf("sb_empty%0d", i), sb[i].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
